// File: rtl/line_fetch_pkg.sv
// Shared types and constants for the line fill / write-back engine.
package line_fetch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBusReq,
    StFill,
    StWb,
    StDone
  } fetch_state_t;

  localparam logic [1:0] FETCH_CMD_WB   = 2'b00;
  localparam logic [1:0] FETCH_CMD_FILL = 2'b01;

  localparam int unsigned WB_FIFO_DEPTH = 2;

endpackage

// File: rtl/line_beat_fifo.sv
// Small synchronous FIFO carrying array read data towards the bus write channel.
module line_beat_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  localparam int unsigned AW       = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CW       = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 pop,
  output logic [DataWidth-1:0] rdata,
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        count
);

  logic [DataWidth-1:0] mem [Depth];
  logic [AW-1:0]        wptr, rptr;
  logic                 do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(Depth - 1)) ? '0 : wptr + AW'(1);
      if (do_pop)  rptr <= (rptr == AW'(Depth - 1)) ? '0 : rptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/line_fetch_ctrl.sv
// Line fill / write-back engine between the cache fetch port, data array and memory bus.
// Optional LINE_FETCH_ERR_CHK_EN adds the sticky err_ovf flag and illegal-command abort.
module line_fetch_ctrl
  import line_fetch_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32,
  localparam int unsigned TW        = $clog2(list_depth),
  localparam int unsigned WW        = $clog2(list_width)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  output logic                  fetch_gnt,
  input  logic [1:0]            fetch_cmd,
  input  logic [TW-1:0]         fetch_tag,
  input  logic [addr_width-1:0] fetch_addr,
  output logic                  fetch_done,
  output logic                  arr_wen,
  output logic [TW+WW-1:0]      arr_waddr,
  output logic [data_width-1:0] arr_wdata,
  input  logic                  arr_wready,
  output logic                  arr_ren,
  output logic [TW+WW-1:0]      arr_raddr,
  input  logic                  arr_rready,
  input  logic [data_width-1:0] arr_rdata,
  input  logic                  arr_rdata_valid,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [addr_width-1:0] bus_addr,
  input  logic                  bus_gnt,
  output logic                  bus_wvalid,
  output logic [data_width-1:0] bus_wdata,
  output logic                  bus_wlast,
  input  logic                  bus_wready,
  input  logic                  bus_rvalid,
  input  logic [data_width-1:0] bus_rdata,
  input  logic                  bus_rlast
`ifdef LINE_FETCH_ERR_CHK_EN
  ,
  output logic                  err_ovf
`endif
);

  localparam logic [WW-1:0] LAST = WW'(list_width - 1);
  localparam int unsigned   FCW  = $clog2(WB_FIFO_DEPTH + 1);

  fetch_state_t          state;
  logic                  is_wb;
  logic [TW-1:0]         tag_ff;
  logic [addr_width-1:0] addr_ff;
  logic [WW-1:0]         wcnt, rcnt, bcnt;
  logic                  hold_valid;
  logic [data_width-1:0] hold_data;
  logic [1:0]            rd_outst;
  logic                  rd_all;

  logic                  fill_beat, hold_free, wr_acc, rd_acc, rd_ret;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [data_width-1:0] fifo_rdata;
  logic [FCW-1:0]        fifo_count;
  logic                  unused_fifo_full;
  logic                  unused_rlast;

  // Burst length is fixed by list_width, so the last-beat flag carries no information.
  assign unused_rlast = bus_rlast;

  assign fill_beat = (state == StFill) && bus_rvalid;
  assign hold_free = !hold_valid || arr_wready;
  assign wr_acc    = hold_valid && arr_wready;
  assign rd_acc    = arr_ren && arr_rready;
  assign rd_ret    = arr_rdata_valid && (state == StWb) && (rd_outst != 2'd0);
  assign fifo_push = arr_rdata_valid && (state == StWb);
  assign fifo_pop  = bus_wvalid && bus_wready;

  assign fetch_gnt  = (state == StIdle);
  assign fetch_done = (state == StDone);
  assign bus_req    = (state == StBusReq);
  assign bus_we     = bus_req && is_wb;
  assign bus_addr   = bus_req ? addr_ff : '0;
  assign arr_wen    = hold_valid;
  assign arr_waddr  = {tag_ff, wcnt};
  assign arr_wdata  = hold_data;
  // Reads in flight plus buffered words never exceed the FIFO depth, so pushes never overflow.
  assign arr_ren    = (state == StWb) && !rd_all &&
                      ((int'(rd_outst) + int'(fifo_count)) < int'(WB_FIFO_DEPTH));
  assign arr_raddr  = {tag_ff, rcnt};
  assign bus_wvalid = !fifo_empty;
  assign bus_wdata  = bus_wvalid ? fifo_rdata : '0;
  assign bus_wlast  = bus_wvalid && (bcnt == LAST);

`ifdef LINE_FETCH_ERR_CHK_EN
  logic cmd_illegal;
  logic err_q;

  assign cmd_illegal = (fetch_cmd != FETCH_CMD_WB) && (fetch_cmd != FETCH_CMD_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((fetch_gnt && fetch_req && cmd_illegal) ||
                 (bus_rvalid && !((state == StFill) && hold_free))) begin
      err_q <= 1'b1;
    end
  end

  assign err_ovf = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      is_wb      <= 1'b0;
      tag_ff     <= '0;
      addr_ff    <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      bcnt       <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      rd_outst   <= '0;
      rd_all     <= 1'b0;
    end else begin
      if (fill_beat && hold_free) begin
        hold_valid <= 1'b1;
        hold_data  <= bus_rdata;
      end else if (wr_acc) begin
        hold_valid <= 1'b0;
      end
      if (wr_acc) wcnt <= wcnt + WW'(1);
      if (rd_acc) begin
        rcnt <= rcnt + WW'(1);
        if (rcnt == LAST) rd_all <= 1'b1;
      end
      case ({rd_acc, rd_ret})
        2'b10:   rd_outst <= rd_outst + 2'd1;
        2'b01:   rd_outst <= rd_outst - 2'd1;
        default: ;
      endcase
      if (fifo_pop) bcnt <= bcnt + WW'(1);

      unique case (state)
        StIdle: begin
          if (fetch_req) begin
            is_wb   <= (fetch_cmd == FETCH_CMD_WB);
            tag_ff  <= fetch_tag;
            addr_ff <= fetch_addr;
`ifdef LINE_FETCH_ERR_CHK_EN
            state   <= cmd_illegal ? StDone : StBusReq;
`else
            state   <= StBusReq;
`endif
          end
        end
        StBusReq: begin
          if (bus_gnt) begin
            state      <= is_wb ? StWb : StFill;
            wcnt       <= '0;
            rcnt       <= '0;
            bcnt       <= '0;
            rd_outst   <= '0;
            rd_all     <= 1'b0;
            hold_valid <= 1'b0;
          end
        end
        StFill:  if (wr_acc && (wcnt == LAST)) state <= StDone;
        StWb:    if (fifo_pop && (bcnt == LAST)) state <= StDone;
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  line_beat_fifo #(
    .DataWidth(data_width),
    .Depth    (WB_FIFO_DEPTH)
  ) u_wb_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(arr_rdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (unused_fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed self-checking bench for line_fetch_ctrl with small array and bus models.
// Build with LINE_FETCH_ERR_CHK_EN defined to cover the err_ovf variant.
module tb_line_fetch_ctrl;

  logic        clk, rst;
  logic        fetch_req, fetch_gnt, fetch_done;
  logic [1:0]  fetch_cmd, fetch_tag;
  logic [31:0] fetch_addr;
  logic        arr_wen, arr_wready, arr_ren, arr_rready, arr_rdata_valid;
  logic [6:0]  arr_waddr, arr_raddr;
  logic [31:0] arr_wdata, arr_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_wvalid, bus_wlast, bus_wready;
  logic        bus_rvalid, bus_rlast;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
`ifdef LINE_FETCH_ERR_CHK_EN
  logic        err_ovf;
`endif

  line_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .fetch_gnt      (fetch_gnt),
    .fetch_cmd      (fetch_cmd),
    .fetch_tag      (fetch_tag),
    .fetch_addr     (fetch_addr),
    .fetch_done     (fetch_done),
    .arr_wen        (arr_wen),
    .arr_waddr      (arr_waddr),
    .arr_wdata      (arr_wdata),
    .arr_wready     (arr_wready),
    .arr_ren        (arr_ren),
    .arr_raddr      (arr_raddr),
    .arr_rready     (arr_rready),
    .arr_rdata      (arr_rdata),
    .arr_rdata_valid(arr_rdata_valid),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_gnt        (bus_gnt),
    .bus_wvalid     (bus_wvalid),
    .bus_wdata      (bus_wdata),
    .bus_wlast      (bus_wlast),
    .bus_wready     (bus_wready),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata),
    .bus_rlast      (bus_rlast)
`ifdef LINE_FETCH_ERR_CHK_EN
    ,
    .err_ovf        (err_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks, errors;
  int          cyc, gnt_cnt, done_cnt, gnt_cyc, done_cyc, req_cnt;
  int          arr_wr_cnt, wb_beats, wlast_cnt, wlast_beat, tb_outst, max_outst;
  int          fills_started, fill_idx, fill_gap, fill_gap_cnt;
  bit          fill_active, wb_toggle, stall_req, new_v, pa_v;
  logic [31:0] new_d, pa_d, cur_base, req_addr;
  logic        req_we;
  logic [31:0] mem [0:127];
  logic [31:0] wb_data [0:31];
  logic [31:0] fill_bases [0:3];

  // One clock: observe DUT at the falling edge, then drive the models just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (fetch_req && fetch_gnt) begin gnt_cnt++; gnt_cyc = cyc; end
    if (fetch_done) begin done_cnt++; done_cyc = cyc; end
    if (bus_req) begin req_addr = bus_addr; req_we = bus_we; end
    if (bus_req && bus_gnt) begin
      req_cnt++;
      if (!bus_we) begin
        fill_active = 1'b1; fill_idx = 0; fill_gap_cnt = 0;
        cur_base = fill_bases[fills_started % 4];
        fills_started++;
      end
    end
    if (arr_wen && arr_wready) begin mem[arr_waddr] = arr_wdata; arr_wr_cnt++; end
    if (arr_rdata_valid && tb_outst > 0) tb_outst--;
    new_v = arr_ren && arr_rready;
    new_d = mem[arr_raddr];
    if (new_v) tb_outst++;
    if (tb_outst > max_outst) max_outst = tb_outst;
    if (bus_wvalid && bus_wready) begin
      if (wb_beats < 32) wb_data[wb_beats] = bus_wdata;
      if (bus_wlast) begin wlast_cnt++; wlast_beat = wb_beats; end
      wb_beats++;
    end
    @(posedge clk);
    #1;
    cyc++;
    arr_rdata_valid = pa_v; arr_rdata = pa_d;
    pa_v = new_v; pa_d = new_d;
    bus_wready = wb_toggle ? !bus_wready : 1'b1;
    arr_wready = !(stall_req && arr_wen && arr_wr_cnt == 5);
    if (!arr_wready) stall_req = 1'b0;
    if (fill_active && fill_gap_cnt == 0) begin
      bus_rvalid = 1'b1; bus_rdata = cur_base + 32'(fill_idx); bus_rlast = (fill_idx == 31);
      fill_idx++; fill_gap_cnt = fill_gap;
      if (fill_idx == 32) fill_active = 1'b0;
    end else begin
      bus_rvalid = 1'b0; bus_rlast = 1'b0;
      if (fill_gap_cnt > 0) fill_gap_cnt--;
    end
  endtask

  // Issues one command and waits for its completion; lat is -1 if it never completes.
  task automatic run_cmd(input logic [1:0] cmd, input logic [1:0] tag, input logic [31:0] addr,
                         output int lat);
    int d0, g0;
    d0 = done_cnt; g0 = gnt_cnt;
    fetch_req = 1'b1; fetch_cmd = cmd; fetch_tag = tag; fetch_addr = addr;
    cycle();
    fetch_req = 1'b0;
    lat = -1;
    if (gnt_cnt != g0) begin
      for (int i = 0; i < 300 && done_cnt == d0; i++) cycle();
      if (done_cnt != d0) lat = done_cyc - gnt_cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    checks++;
    if ({fetch_gnt, fetch_done, bus_req, bus_we, bus_wvalid, bus_wlast, arr_wen, arr_ren}
        !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 10000000",
               {fetch_gnt, fetch_done, bus_req, bus_we, bus_wvalid, bus_wlast, arr_wen, arr_ren});
    end
    checks++;
    if ({bus_addr, bus_wdata, arr_wdata, arr_waddr, arr_raddr} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h %h want 0", bus_addr, bus_wdata, arr_wdata,
               arr_waddr, arr_raddr);
    end
  endtask

  task automatic test_fill();
    int lat, d0;
    fills_started = 0; fill_bases[0] = 32'd0; fill_gap = 0; d0 = done_cnt;
    run_cmd(2'b01, 2'd2, 32'h100, lat);
    repeat (3) cycle();
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL fill_latency got %0d want 35", lat); end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL fill_done_pulses got %0d want 1", done_cnt - d0);
    end
    checks++;
    if ({req_we, req_addr} !== {1'b0, 32'h100}) begin
      errors++; $display("FAIL fill_bus_req got we=%b addr=%h want we=0 addr=100", req_we, req_addr);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[64 + i] !== 32'(i)) begin
        errors++; $display("FAIL fill_word%0d got %h want %h", i, mem[64 + i], i);
      end
    end
  endtask

  task automatic test_write_back();
    int lat;
    for (int i = 0; i < 32; i++) mem[32 + i] = 32'hA0 + 32'(i);
    wb_beats = 0; wlast_cnt = 0; wlast_beat = -1; max_outst = 0; wb_toggle = 1'b1;
    run_cmd(2'b00, 2'd1, 32'h200, lat);
    wb_toggle = 1'b0;
    checks++;
    if (lat < 0) begin errors++; $display("FAIL wb_timeout got %0d want completion", lat); end
    checks++;
    if ({req_we, req_addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL wb_bus_req got we=%b addr=%h want we=1 addr=200", req_we, req_addr);
    end
    checks++;
    if (wb_beats !== 32) begin errors++; $display("FAIL wb_beats got %0d want 32", wb_beats); end
    checks++;
    if (wlast_cnt !== 1 || wlast_beat !== 31) begin
      errors++;
      $display("FAIL wb_wlast got count=%0d beat=%0d want count=1 beat=31", wlast_cnt, wlast_beat);
    end
    checks++;
    if (max_outst > 2) begin errors++; $display("FAIL wb_outstanding got %0d want <=2", max_outst); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wb_data[i] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL wb_beat%0d got %h want %h", i, wb_data[i], 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_fill_stall();
    int lat;
    fills_started = 0; fill_bases[0] = 32'h1000; fill_gap = 1;
    arr_wr_cnt = 0; stall_req = 1'b1;
    run_cmd(2'b01, 2'd0, 32'h400, lat);
    fill_gap = 0;
    checks++;
    if (stall_req !== 1'b0 || arr_wr_cnt !== 32) begin
      errors++;
      $display("FAIL stall_writes got stall_pending=%b writes=%0d want 0 32", stall_req, arr_wr_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[i] !== 32'h1000 + 32'(i)) begin
        errors++; $display("FAIL stall_word%0d got %h want %h", i, mem[i], 32'h1000 + 32'(i));
      end
    end
`ifdef LINE_FETCH_ERR_CHK_EN
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL stall_err_ovf got %b want 0", err_ovf); end
`endif
  endtask

  task automatic test_reset_mid_wb();
    int lat;
    wb_beats = 0;
    fetch_req = 1'b1; fetch_cmd = 2'b00; fetch_tag = 2'd1; fetch_addr = 32'h200;
    cycle();
    fetch_req = 1'b0;
    for (int i = 0; i < 100 && wb_beats < 10; i++) cycle();
    checks++;
    if (wb_beats < 10) begin errors++; $display("FAIL rstwb_reach got %0d want >=10", wb_beats); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({fetch_gnt, bus_wvalid, arr_ren, fetch_done} !== 4'b1000) begin
      errors++;
      $display("FAIL rstwb_idle got %b want 1000", {fetch_gnt, bus_wvalid, arr_ren, fetch_done});
    end
    pa_v = 1'b0; tb_outst = 0; arr_rdata_valid = 1'b0;
    fills_started = 0; fill_bases[0] = 32'h3000;
    run_cmd(2'b01, 2'd3, 32'h600, lat);
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL rstwb_fill_latency got %0d want 35", lat); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mem[96 + i] !== 32'h3000 + 32'(i)) begin
        errors++; $display("FAIL rstwb_word%0d got %h want %h", i, mem[96 + i], 32'h3000 + 32'(i));
      end
    end
  endtask

  task automatic test_illegal_cmd();
    int lat, r0;
    r0 = req_cnt;
    fills_started = 0; fill_bases[0] = 32'h7000;
    run_cmd(2'b11, 2'd1, 32'h800, lat);
`ifdef LINE_FETCH_ERR_CHK_EN
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
    checks++;
    if (req_cnt !== r0) begin errors++; $display("FAIL illegal_bus_req got %0d want 0", req_cnt - r0); end
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL illegal_err_ovf got %b want 1", err_ovf); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL illegal_err_clear got %b want 0", err_ovf); end
`else
    checks++;
    if (lat !== 35) begin errors++; $display("FAIL illegal_as_fill_latency got %0d want 35", lat); end
    checks++;
    if (req_cnt - r0 !== 1 || req_we !== 1'b0) begin
      errors++; $display("FAIL illegal_as_fill_req got n=%0d we=%b want 1 0", req_cnt - r0, req_we);
    end
    checks++;
    if (mem[32 + 17] !== 32'h7011) begin
      errors++; $display("FAIL illegal_as_fill_word got %h want 00007011", mem[32 + 17]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int d0, g0, d1;
    fills_started = 0; fill_bases[0] = 32'h5000; fill_bases[1] = 32'h6000;
    d0 = done_cnt; g0 = gnt_cnt; d1 = -1;
    fetch_req = 1'b1; fetch_cmd = 2'b01; fetch_tag = 2'd0; fetch_addr = 32'hA00;
    cycle();
    fetch_tag = 2'd3; fetch_addr = 32'hB00;
    for (int i = 0; i < 200 && gnt_cnt < g0 + 2; i++) begin
      cycle();
      if (done_cnt == d0 + 1 && d1 < 0) d1 = done_cyc;
    end
    fetch_req = 1'b0;
    for (int i = 0; i < 200 && done_cnt < d0 + 2; i++) cycle();
    checks++;
    if (gnt_cnt - g0 !== 2 || gnt_cyc !== d1 + 1) begin
      errors++;
      $display("FAIL b2b_second_grant got grants=%0d cyc=%0d want 2 cyc=%0d", gnt_cnt - g0,
               gnt_cyc, d1 + 1);
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0);
    end
    for (int i = 0; i < 32; i += 5) begin
      checks++;
      if (mem[i] !== 32'h5000 + 32'(i) || mem[96 + i] !== 32'h6000 + 32'(i)) begin
        errors++;
        $display("FAIL b2b_word%0d got %h %h want %h %h", i, mem[i], mem[96 + i],
                 32'h5000 + 32'(i), 32'h6000 + 32'(i));
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; gnt_cnt = 0; done_cnt = 0; gnt_cyc = 0; done_cyc = 0;
    req_cnt = 0; arr_wr_cnt = 0; wb_beats = 0; wlast_cnt = 0; wlast_beat = -1;
    tb_outst = 0; max_outst = 0; fills_started = 0; fill_idx = 0; fill_gap = 0;
    fill_gap_cnt = 0; fill_active = 1'b0; wb_toggle = 1'b0; stall_req = 1'b0;
    new_v = 1'b0; pa_v = 1'b0; new_d = '0; pa_d = '0; cur_base = '0; req_addr = '0;
    req_we = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) fill_bases[i] = '0;
    rst = 1'b1; fetch_req = 1'b0; fetch_cmd = 2'b00; fetch_tag = 2'd0; fetch_addr = '0;
    arr_wready = 1'b1; arr_rready = 1'b1; arr_rdata = '0; arr_rdata_valid = 1'b0;
    bus_gnt = 1'b1; bus_wready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0; bus_rlast = 1'b0;

    test_reset();
    test_fill();
    test_write_back();
    test_fill_stall();
    test_reset_mid_wb();
    test_illegal_cmd();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
